// File: rtl/io_port_ctrl_if.sv
// CPU-side byte bus for the I/O endpoint: access qualifier, select, direction,
// write data, registered read data and the TX almost-full back-pressure flag.
interface io_port_ctrl_if;
  logic       io_en;
  logic [2:0] io_sel;
  logic       io_wr;
  logic [7:0] io_din;
  logic [7:0] io_dout;
  logic       io_buffer_full;

  modport master (
    output io_en, io_sel, io_wr, io_din,
    input  io_dout, io_buffer_full
  );

  modport slave (
    input  io_en, io_sel, io_wr, io_din,
    output io_dout, io_buffer_full
  );
endinterface

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O endpoint: UART TX/RX byte FIFOs, cycle counter with snapshot
// reads, and the program-stop sequencer. Define IO_DROP_CNT_EN to add dbg_drop_cnt.
module io_port_ctrl #(
  parameter int unsigned TX_DEPTH_LOG2 = 4,
  parameter int unsigned RX_DEPTH_LOG2 = 4,
  parameter int unsigned FULL_MARGIN   = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  io_port_ctrl_if.slave       io,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                program_end
`ifdef IO_DROP_CNT_EN
  ,
  output logic [15:0]         dbg_drop_cnt
`endif
);

  localparam int unsigned TXN = 1 << TX_DEPTH_LOG2;
  localparam int unsigned RXN = 1 << RX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2+1:0] TX_THRESH = (TX_DEPTH_LOG2+2)'(TXN - FULL_MARGIN);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_NUL, ST_DONE} state_t;
  state_t state, state_nxt;

  logic [7:0]             tx_mem [TXN];
  logic [TX_DEPTH_LOG2:0] tx_wr_ptr, tx_rd_ptr;
  logic [7:0]             rx_mem [RXN];
  logic [RX_DEPTH_LOG2:0] rx_wr_ptr, rx_rd_ptr;
  logic [31:0]            counter, snapshot;
  logic [7:0]             rd_byte;

  logic access, wr_acc, rd_acc, stop_req;
  logic tx_empty, tx_full, tx_push_req, tx_push, tx_pop;
  logic rx_empty, rx_full, rx_push, rx_pop;
  logic [TX_DEPTH_LOG2:0]   tx_cnt;
  logic [TX_DEPTH_LOG2+1:0] tx_cnt_nxt;

  assign access   = io.io_en && rdy_in;
  assign wr_acc   = access && io.io_wr && (state == ST_RUN);
  assign rd_acc   = access && !io.io_wr;
  assign stop_req = wr_acc && (io.io_sel == 3'd4);

  // Full/empty from pointer MSBs; equal low bits with differing MSB means full.
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[TX_DEPTH_LOG2] != tx_rd_ptr[TX_DEPTH_LOG2]) &&
                    (tx_wr_ptr[TX_DEPTH_LOG2-1:0] == tx_rd_ptr[TX_DEPTH_LOG2-1:0]);
  assign tx_cnt   = tx_wr_ptr - tx_rd_ptr;

  assign tx_pop      = tx_ready && !tx_empty;
  assign tx_push_req = wr_acc && (io.io_sel == 3'd0) && (io.io_din != 8'h00);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_cnt_nxt  = (TX_DEPTH_LOG2+2)'(tx_cnt) + (TX_DEPTH_LOG2+2)'(tx_push)
                     - (TX_DEPTH_LOG2+2)'(tx_pop);

  assign tx_valid    = !tx_empty || (state == ST_NUL);
  assign tx_data     = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr[TX_DEPTH_LOG2-1:0]];
  assign program_end = (state == ST_DONE);

  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[RX_DEPTH_LOG2] != rx_rd_ptr[RX_DEPTH_LOG2]) &&
                    (rx_wr_ptr[RX_DEPTH_LOG2-1:0] == rx_rd_ptr[RX_DEPTH_LOG2-1:0]);
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = rd_acc && (io.io_sel == 3'd0) && !rx_empty;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (stop_req) state_nxt = ST_DRAIN;
      ST_DRAIN: if (tx_empty) state_nxt = ST_NUL;
      ST_NUL:   if (tx_ready) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    rd_byte = '0;
    case (io.io_sel)
      3'd0:    rd_byte = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr[RX_DEPTH_LOG2-1:0]];
      3'd4:    rd_byte = counter[7:0];
      3'd5:    rd_byte = snapshot[15:8];
      3'd6:    rd_byte = snapshot[23:16];
      3'd7:    rd_byte = snapshot[31:24];
      default: rd_byte = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_DEPTH_LOG2-1:0]] <= io.io_din;
    if (rx_push) rx_mem[rx_wr_ptr[RX_DEPTH_LOG2-1:0]] <= rx_data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state             <= ST_RUN;
      tx_wr_ptr         <= '0;
      tx_rd_ptr         <= '0;
      rx_wr_ptr         <= '0;
      rx_rd_ptr         <= '0;
      counter           <= '0;
      snapshot          <= '0;
      io.io_dout        <= '0;
      io.io_buffer_full <= 1'b0;
    end else begin
      state             <= state_nxt;
      io.io_buffer_full <= (tx_cnt_nxt >= TX_THRESH);
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rdy_in && (state == ST_RUN)) counter <= counter + 32'd1;
      if (rd_acc) io.io_dout <= rd_byte;
      if (rd_acc && (io.io_sel == 3'd4)) snapshot <= counter;
    end
  end

`ifdef IO_DROP_CNT_EN
  logic        tx_drop, rx_drop;
  logic [16:0] drop_sum;

  assign tx_drop  = tx_push_req && !tx_push;
  assign rx_drop  = rx_valid && rx_full;
  assign drop_sum = {1'b0, dbg_drop_cnt} + 17'(tx_drop) + 17'(rx_drop);

  always_ff @(posedge clk_in) begin
    if (!rst_in) dbg_drop_cnt <= '0;
    else         dbg_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl: TX bytes are checked against a scoreboard
// queue filled as writes are issued; register reads are checked directly.
module tb_io_port_ctrl;
  logic       clk_in = 1'b0;
  logic       rst_in, rdy_in, tx_ready, rx_valid, tx_valid, program_end;
  logic [7:0] tx_data, rx_data;
`ifdef IO_DROP_CNT_EN
  logic [15:0] dbg_drop_cnt;
`endif

  io_port_ctrl_if bus ();

  io_port_ctrl #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4), .FULL_MARGIN(2)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .io          (bus),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .program_end (program_end)
`ifdef IO_DROP_CNT_EN
    ,
    .dbg_drop_cnt(dbg_drop_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Handshakes are observed at the negedge before the edge that consumes them.
  task automatic tick();
    @(negedge clk_in);
    if (tx_valid && tx_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL tx_extra: got %0h want none", tx_data);
      end
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_b});
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] d);
    bus.io_en = 1'b1; bus.io_wr = 1'b1; bus.io_sel = sel; bus.io_din = d;
    tick();
    bus.io_en = 1'b0; bus.io_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel);
    bus.io_en = 1'b1; bus.io_wr = 1'b0; bus.io_sel = sel;
    tick();
    bus.io_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    bus.io_en = 1'b0; bus.io_wr = 1'b0; bus.io_sel = '0; bus.io_din = '0;

    // 1. reset values
    do_reset();
    chk("rst_dout", {24'b0, bus.io_dout}, 32'h0);
    chk("rst_full", {31'b0, bus.io_buffer_full}, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
    chk("rst_prog_end", {31'b0, program_end}, 32'h0);
    tick();
    rd(3'd4);
    chk("early_snap_le1", {31'b0, (bus.io_dout <= 8'h01)}, 32'h1);

    // 2. zero writes are filtered
    tx_ready = 1'b1;
    exp_q.push_back(8'h41); wr(3'd0, 8'h41);
    wr(3'd0, 8'h00);
    exp_q.push_back(8'h42); wr(3'd0, 8'h42);
    repeat (4) tick();
    chk("t2_q_empty", exp_q.size(), 32'h0);

    // 3. almost-full threshold and overflow drop
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(8'h30 + i));
      wr(3'd0, 8'(8'h30 + i));
      if (i == 12) chk("full_at_13", {31'b0, bus.io_buffer_full}, 32'h0);
      if (i == 13) chk("full_at_14", {31'b0, bus.io_buffer_full}, 32'h1);
    end
    chk("full_at_16", {31'b0, bus.io_buffer_full}, 32'h1);
`ifdef IO_DROP_CNT_EN
    chk("drop_cnt_tx", {16'b0, dbg_drop_cnt}, 32'h1);
`endif
    tx_ready = 1'b1;
    repeat (20) tick();
    chk("t3_q_empty", exp_q.size(), 32'h0);
    chk("t3_full_clr", {31'b0, bus.io_buffer_full}, 32'h0);
    chk("t3_tx_idle", {31'b0, tx_valid}, 32'h0);

    // 5. RX FIFO, including push racing a read of an empty FIFO
    rx_valid = 1'b1; rx_data = 8'h55;
    tick();
    rx_valid = 1'b0;
    rd(3'd0);
    chk("rx_55", {24'b0, bus.io_dout}, 32'h55);
    rd(3'd0);
    chk("rx_empty", {24'b0, bus.io_dout}, 32'h0);
    rx_valid = 1'b1; rx_data = 8'hA5;
    rd(3'd0);
    rx_valid = 1'b0;
    chk("rx_race", {24'b0, bus.io_dout}, 32'h0);
    rd(3'd0);
    chk("rx_kept", {24'b0, bus.io_dout}, 32'hA5);
    tick();
    chk("dout_hold", {24'b0, bus.io_dout}, 32'hA5);

    // 6. stop sequence: drain, NUL byte, sticky end, writes ignored
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'(8'h61 + i));
      wr(3'd0, 8'(8'h61 + i));
    end
    exp_q.push_back(8'h00);
    wr(3'd4, 8'h00);
    tx_ready = 1'b1;
    for (int n = 0; n < 20 && !program_end; n++) tick();
    chk("prog_end", {31'b0, program_end}, 32'h1);
    chk("t6_q_empty", exp_q.size(), 32'h0);
    wr(3'd0, 8'h41);
    repeat (3) tick();
    chk("done_no_tx", {31'b0, tx_valid}, 32'h0);
    chk("done_sticky", {31'b0, program_end}, 32'h1);

    // 4. counter: 100 running cycles, 20 paused
    do_reset();
    chk("rst2_prog_end", {31'b0, program_end}, 32'h0);
    repeat (100) tick();
    rdy_in = 1'b0;
    repeat (20) tick();
    rdy_in = 1'b1;
    rd(3'd4);
    chk("cnt_b0", {24'b0, bus.io_dout}, 32'h64);
    rd(3'd5);
    chk("cnt_b1", {24'b0, bus.io_dout}, 32'h0);
    rd(3'd6);
    chk("cnt_b2", {24'b0, bus.io_dout}, 32'h0);
    rd(3'd7);
    chk("cnt_b3", {24'b0, bus.io_dout}, 32'h0);
    rd(3'd4);
    chk("cnt_recap", {24'b0, bus.io_dout}, 32'h68);
    rdy_in = 1'b0;
    rd(3'd0);
    rdy_in = 1'b1;
    chk("rdy_gate", {24'b0, bus.io_dout}, 32'h68);

    // reset mid-transfer discards queued bytes
    tx_ready = 1'b0;
    wr(3'd0, 8'h11);
    wr(3'd0, 8'h22);
    chk("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
    do_reset();
    chk("rst_discard", {31'b0, tx_valid}, 32'h0);
`ifdef IO_DROP_CNT_EN
    chk("drop_cnt_rst", {16'b0, dbg_drop_cnt}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
